// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: load/store initiator for a synchronous-read data memory.
// Optional MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module lsu_mem_initiator #(
  parameter int          WORD_IDX_W = 8,
  parameter int          MEM_ADDR_W = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_write,
  output logic [3:0]            byte_en,
  output logic [MEM_ADDR_W-1:0] write_addr,
  output logic [MEM_ADDR_W-1:0] read_addr,
  output logic [31:0]           write_data,
  input  logic [31:0]           read_data
);
  typedef enum logic [2:0] {IDLE, WR, RD, FMT, RESP} state_t;
  state_t state_q, state_d;
  logic [1:0] size_q, size_d, lane_q, lane_d;
  logic uns_q, uns_d;
  logic resp_valid_q, resp_valid_d, resp_err_q, resp_err_d, mem_write_q, mem_write_d;
  logic [31:0] resp_rdata_q, resp_rdata_d, write_data_q, write_data_d;
  logic [3:0] byte_en_q, byte_en_d;
  logic [MEM_ADDR_W-1:0] write_addr_q, write_addr_d, read_addr_q, read_addr_d;
  logic [MEM_ADDR_W-1:0] idx;
  logic out_range, misalign, err;
  logic [3:0] be;
  logic [31:0] wd, load_val;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  assign idx = {{(MEM_ADDR_W-WORD_IDX_W){1'b0}}, req_addr[WORD_IDX_W+1:2]};
  assign out_range = req_addr[31:WORD_IDX_W+2] != BASE_ADDR[31:WORD_IDX_W+2];
`ifdef MISALIGN_TRAP_EN
  assign misalign = (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && |req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif
  assign err = req_size == 2'b11 || out_range || misalign;
  assign be = req_size == 2'b00 ? 4'b0001 << req_addr[1:0] :
              req_size == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
              req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
  assign ld_b = read_data[{lane_q, 3'b000} +: 8];
  assign ld_h = read_data[{lane_q[1], 4'b0000} +: 16];
  assign load_val = size_q == 2'b00 ? {{24{~uns_q & ld_b[7]}}, ld_b} :
                    size_q == 2'b01 ? {{16{~uns_q & ld_h[15]}}, ld_h} : read_data;
  always_comb begin
    state_d = state_q;
    size_d = size_q;
    lane_d = lane_q;
    uns_d = uns_q;
    resp_valid_d = 1'b0;
    resp_err_d = 1'b0;
    resp_rdata_d = '0;
    mem_write_d = 1'b0;
    byte_en_d = '0;
    write_data_d = write_data_q;
    write_addr_d = write_addr_q;
    read_addr_d = read_addr_q;
    case (state_q)
      IDLE: if (req_valid) begin
        size_d = req_size;
        lane_d = req_addr[1:0];
        uns_d = req_unsigned;
        if (err) begin
          state_d = RESP;
          resp_valid_d = 1'b1;
          resp_err_d = 1'b1;
        end else if (req_we) begin
          state_d = WR;
          mem_write_d = 1'b1;
          byte_en_d = be;
          write_data_d = wd;
          write_addr_d = idx;
        end else begin
          state_d = RD;
          read_addr_d = idx;
        end
      end
      WR: begin
        state_d = RESP;
        resp_valid_d = 1'b1;
      end
      RD: state_d = FMT;
      FMT: begin
        state_d = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_val;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      size_q <= '0;
      lane_q <= '0;
      uns_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_write_q <= 1'b0;
      byte_en_q <= '0;
      write_data_q <= '0;
      write_addr_q <= '0;
      read_addr_q <= '0;
    end else begin
      state_q <= state_d;
      size_q <= size_d;
      lane_q <= lane_d;
      uns_q <= uns_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_write_q <= mem_write_d;
      byte_en_q <= byte_en_d;
      write_data_q <= write_data_d;
      write_addr_q <= write_addr_d;
      read_addr_q <= read_addr_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign resp_valid = resp_valid_q;
  assign resp_err = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_write = mem_write_q;
  assign byte_en = byte_en_q;
  assign write_data = write_data_q;
  assign write_addr = write_addr_q;
  assign read_addr = read_addr_q;
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: table-driven scoreboard bench with a 1-cycle synchronous-read memory model.
module tb_lsu_mem_initiator;
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wd;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_err, mem_write;
  logic [31:0] resp_rdata, write_data, read_data;
  logic [3:0] byte_en;
  logic [11:0] write_addr, read_addr;
  logic [31:0] mem [256];
  vec_t vecs[$];
  vec_t sb_q[$];
  int n_vec = 0, n_err = 0;
  lsu_mem_initiator dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_write(mem_write),
    .byte_en(byte_en), .write_addr(write_addr), .read_addr(read_addr), .write_data(write_data),
    .read_data(read_data)
  );
  always #5 clk = ~clk;
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (mem_write)
      for (int i = 0; i < 4; i++)
        if (byte_en[i]) mem[write_addr[7:0]][8*i +: 8] <= write_data[8*i +: 8];
    read_data <= mem[read_addr[7:0]];
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic void add(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic err,
                              input logic [31:0] rdata, input logic [3:0] be, input logic [31:0] wd);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.be = be; v.wd = wd;
    vecs.push_back(v);
  endfunction
  // Called at a negedge; returns at a negedge with the DUT idle again.
  task automatic run(input vec_t v, input int id);
    int w, lat, pulses, ready_after;
    logic [7:0] mw;
    logic be_leak;
    vec_t e;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    chk($sformatf("v%0d ready_wait", id), 32'(w < 20), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    sb_q.push_back(v);
    lat = 0; pulses = 0; ready_after = 0; mw = '0; be_leak = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      mw[k-1] = mem_write;
      if (!mem_write && byte_en != 4'b0000) be_leak = 1'b1;
      if (k == 1 && !v.err && v.we) begin
        chk($sformatf("v%0d byte_en", id), 32'(byte_en), 32'(v.be));
        chk($sformatf("v%0d write_data", id), write_data, v.wd);
        chk($sformatf("v%0d write_addr", id), 32'(write_addr), 32'(v.addr[9:2]));
      end
      if (k == 1 && !v.err && !v.we)
        chk($sformatf("v%0d read_addr", id), 32'(read_addr), 32'(v.addr[9:2]));
      if (lat != 0 && k == lat + 1) ready_after = int'(req_ready);
      if (resp_valid) begin
        pulses++;
        if (lat == 0) begin
          lat = k;
          if (sb_q.size() == 0) chk($sformatf("v%0d sb_empty", id), 32'd1, 32'd0);
          else begin
            e = sb_q.pop_front();
            chk($sformatf("v%0d resp_err", id), 32'(resp_err), 32'(e.err));
            chk($sformatf("v%0d resp_rdata", id), resp_rdata, e.rdata);
          end
        end
      end
    end
    chk($sformatf("v%0d pulses", id), pulses, 1);
    chk($sformatf("v%0d latency", id), lat, v.err ? 1 : v.we ? 2 : 3);
    chk($sformatf("v%0d ready_after", id), ready_after, 1);
    chk($sformatf("v%0d mem_write_pattern", id), 32'(mw), (v.we && !v.err) ? 32'h1 : 32'h0);
    chk($sformatf("v%0d byte_en_idle", id), 32'(be_leak), 32'd0);
  endtask
  initial begin
    vec_t a;
    int pulses;
    add(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 4'hF, 32'hDEADBEEF);
    add(0, 2'b00, 0, 32'h13, 32'h0, 0, 32'hFFFFFFDE, 4'h0, 32'h0);
    add(0, 2'b01, 1, 32'h10, 32'h0, 0, 32'h0000BEEF, 4'h0, 32'h0);
    add(1, 2'b00, 0, 32'h11, 32'h5A, 0, 32'h0, 4'b0010, 32'h5A5A5A5A);
    add(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEAD5AEF, 4'h0, 32'h0);
`ifdef MISALIGN_TRAP_EN
    add(0, 2'b10, 0, 32'h12, 32'h0, 1, 32'h0, 4'h0, 32'h0);
`else
    add(0, 2'b10, 0, 32'h12, 32'h0, 0, 32'hDEAD5AEF, 4'h0, 32'h0);
`endif
    add(1, 2'b10, 0, 32'h400, 32'h11111111, 1, 32'h0, 4'h0, 32'h0);
    add(0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h0, 4'h0, 32'h0);
    add(1, 2'b11, 0, 32'h10, 32'h22, 1, 32'h0, 4'h0, 32'h0);
    add(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEAD5AEF, 4'h0, 32'h0);
    add(1, 2'b01, 0, 32'h22, 32'h12348765, 0, 32'h0, 4'b1100, 32'h87658765);
    add(0, 2'b01, 0, 32'h22, 32'h0, 0, 32'hFFFF8765, 4'h0, 32'h0);
    add(0, 2'b01, 1, 32'h22, 32'h0, 0, 32'h00008765, 4'h0, 32'h0);
    add(0, 2'b01, 0, 32'h20, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    add(0, 2'b00, 0, 32'h11, 32'h0, 0, 32'h5A, 4'h0, 32'h0);
    add(0, 2'b00, 1, 32'h13, 32'h0, 0, 32'hDE, 4'h0, 32'h0);
`ifdef MISALIGN_TRAP_EN
    add(1, 2'b01, 0, 32'h23, 32'hAAAA4321, 1, 32'h0, 4'h0, 32'h0);
    add(0, 2'b01, 0, 32'h22, 32'h0, 0, 32'hFFFF8765, 4'h0, 32'h0);
`else
    add(1, 2'b01, 0, 32'h23, 32'hAAAA4321, 0, 32'h0, 4'b1100, 32'h43214321);
    add(0, 2'b01, 0, 32'h22, 32'h0, 0, 32'h00004321, 4'h0, 32'h0);
`endif
    add(1, 2'b00, 0, 32'h3FF, 32'h80, 0, 32'h0, 4'b1000, 32'h80808080);
    add(0, 2'b00, 0, 32'h3FF, 32'h0, 0, 32'hFFFFFF80, 4'h0, 32'h0);
    add(0, 2'b00, 1, 32'h3FF, 32'h0, 0, 32'h80, 4'h0, 32'h0);
    add(0, 2'b10, 0, 32'hFFFFFFFC, 32'h0, 1, 32'h0, 4'h0, 32'h0);
    add(1, 2'b10, 0, 32'h0, 32'h01020304, 0, 32'h0, 4'hF, 32'h01020304);
    add(0, 2'b10, 0, 32'h0, 32'h0, 0, 32'h01020304, 4'h0, 32'h0);
    add(0, 2'b00, 1, 32'h1, 32'h0, 0, 32'h03, 4'h0, 32'h0);
    add(0, 2'b01, 0, 32'h2, 32'h0, 0, 32'h00000102, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp", {29'd0, resp_valid, resp_err, mem_write}, 32'd0);
    chk("reset rdata", resp_rdata, 32'd0);
    chk("reset byte_en", 32'(byte_en), 32'd0);
    chk("reset addrs", {8'd0, write_addr, read_addr}, 32'd0);
    chk("reset write_data", write_data, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    foreach (vecs[i]) run(vecs[i], i);
    // Abort a load with reset while it sits in RD: no response may ever appear.
    a = vecs[4];
    req_valid = 1'b1; req_we = a.we; req_size = a.size; req_unsigned = a.uns;
    req_addr = a.addr; req_wdata = a.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort in_rd", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort ready", 32'(req_ready), 32'd1);
    chk("abort read_addr", 32'(read_addr), 32'd0);
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      pulses += int'(resp_valid) + int'(mem_write);
    end
    chk("abort no_resp", pulses, 0);
    a.we = 1'b1; a.addr = 32'h44; a.wdata = 32'hCAFEF00D; a.err = 1'b0; a.rdata = 32'h0;
    a.be = 4'hF; a.wd = 32'hCAFEF00D;
    run(a, 100);
    a.we = 1'b0; a.rdata = 32'hCAFEF00D;
    run(a, 101);
    chk("sb drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
